fpu_share_arbiter: RTL and testbench
====================================

Name: fpu_share_arbiter

Overview:
- Shares one fpu_core between NUM_REQ requesters (core-side ports).
- Round-robin arbitrates requests and muxes operand, command and rounding mode into the FPU issue port.
- Tracks the winner ID through a shift pipeline matched to the FPU latency.
- Routes Result_DO and the flags back as a one-hot response pulse to the issuing requester.

Parameters:
- NUM_REQ, 4: number of requesters, 1..16.
- FPU_LATENCY, 1: cycles from FPU Enable_SI to Valid_SO; must be >=1.
- ID_W, $clog2(NUM_REQ) (min 1): requester index width; derived, not overridden.

Ports:
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset; asynchronous, active-high
- Req_SI  in  NUM_REQ  per-requester request
- Gnt_SO  out  NUM_REQ  one-hot grant; same-cycle combinational
- Operand_a_DI  in  NUM_REQ*C_FPU01_OP  packed operand a per requester
- Operand_b_DI  in  NUM_REQ*C_FPU01_OP  packed operand b
- OP_SI  in  NUM_REQ*C_FPU01_CMD  packed command
- RM_SI  in  NUM_REQ*C_FPU01_RM  packed rounding mode
- FpuEnable_SO  out  1  to fpu_core Enable_SI
- FpuOperand_a_DO / FpuOperand_b_DO  out  C_FPU01_OP  to fpu_core
- FpuOP_SO  out  C_FPU01_CMD  to fpu_core
- FpuRM_SO  out  C_FPU01_RM  to fpu_core
- FpuResult_DI  in  C_FPU01_OP  from fpu_core Result_DO
- FpuValid_SI  in  1  from fpu_core Valid_SO
- FpuFlags_DI  in  6  {OF,UF,Zero,IX,IV,Inf} from fpu_core
- RespValid_SO  out  NUM_REQ  one-hot response pulse
- Result_DO  out  C_FPU01_OP  result, broadcast to all requesters
- Flags_DO  out  6  flags, broadcast
- IdErr_SO  out  1  sticky: FpuValid_SI disagrees with the ID pipeline

Behaviour:
- Reset (asserted): RR pointer = 0; ID pipeline valid bits = 0; IdErr_SO = 0.
  - RespValid_SO = 0, Result_DO = 0, Flags_DO = 0 (registered variant).
  - Combinational outputs follow the zeroed state: Gnt_SO = 0 while reset is held.
- Arbitration (combinational, each cycle):
  - Scan indices ptr, ptr+1, ..., ptr+NUM_REQ-1 mod NUM_REQ.
  - The first with Req_SI=1 wins; Gnt_SO is one-hot to it.
  - No request -> Gnt_SO = 0.
- Issue: a transfer occurs when Req&Gnt; requesters do not wait.
  - FpuEnable_SO = |Req_SI.
  - Fpu* buses carry the winner's fields; they are 0 when idle.
  - The FPU has no backpressure; one issue per cycle is accepted.
- Pointer update: on a grant to index i, ptr <= (i+1) mod NUM_REQ; no grant -> ptr holds.
  - NUM_REQ=1: ptr is constant 0.
- ID pipeline: FPU_LATENCY stages of {valid, id}.
  - Stage0 <= {FpuEnable_SO, winner}; stage k <= stage k-1.
- Response: when tail.valid, RespValid_SO[tail.id] = 1 for one cycle.
  - Result_DO = FpuResult_DI; Flags_DO = FpuFlags_DI.
  - Total latency from Req&Gnt to RespValid = FPU_LATENCY cycles (base build).
- Consistency: tail.valid != FpuValid_SI sets IdErr_SO (sticky until reset).
  - Response gating uses tail.valid only.
- Back-to-back: with all requesters requesting continuously, grants rotate 0,1,2,3,0...
  - Responses return in issue order, one per cycle.
- Simultaneous grant and response for the same requester in one cycle: legal, independent.
- Reset mid-operation: in-flight IDs are discarded; no RespValid for them after deassertion.
  - The top ties fpu_core Rst_RBI = ~Rst_RI so FPU state is flushed together.

Optional Feature:
- FPU_ARB_RESP_REG_EN defined: Result_DO, Flags_DO and RespValid_SO are registered (reset 0).
  - Latency becomes FPU_LATENCY+1.
  - IdErr_SO check unchanged, still on the unregistered tail.
- Undefined: response outputs are combinational from the FPU outputs, as above.

Decomposition:
- fpu_defs holds:
  - C_FPU01_FLAGS = 6;
  - the flag bit index constants C_FPU01_FLAG_OF..C_FPU01_FLAG_INF;
  - typedef fpu_arb_id_t, a struct {logic valid; logic [3:0] id}, sized for the 16-requester maximum.
- Sub-module fpu_rr_arbiter:
  - in: Req, ptr; out: one-hot Gnt, winner index, any.
  - Pure combinational, reused by the parent; the parent owns ptr and the ID pipeline.

Test Plan:
- Single request: R1 issues ADD 0x3F800000 + 0x40000000, RM=0.
  - Gnt_SO=0b0010 that cycle; after FPU_LATENCY=1 cycle, RespValid_SO=0b0010, Result_DO=0x40400000, flags 0.
- All four requesting continuously for 8 cycles from ptr=0.
  - Grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle; no gaps.
- R2 and R3 request with ptr=3: R3 wins, ptr becomes 0.
  - Next cycle with the same requests, R2 wins.
- R0 MUL 0x40000000 * 0x40400000, then R1 SUB 0x3F800000 - 0x3F800000 back-to-back.
  - R0 gets 0x40C00000; R1 gets 0x00000000 with the Zero flag set.
- Reset pulse one cycle after issue: no RespValid_SO afterwards; ptr=0; IdErr_SO=0.
- Force FpuValid_SI=1 with an empty pipeline: IdErr_SO=1 and remains set; RespValid_SO stays 0.
- With FPU_ARB_RESP_REG_EN: repeat the first scenario; response appears at cycle 2 with identical values.

Source files
------------

// File: rtl/fpu_defs.sv
// rtl/fpu_defs.sv - shared FPU widths, flag indices and arbiter ID-pipeline type
package fpu_defs;

   localparam int C_FPU01_OP    = 32;
   localparam int C_FPU01_CMD   = 4;
   localparam int C_FPU01_RM    = 2;
   localparam int C_FPU01_FLAGS = 6;

   // Flags bus ordering is {OF,UF,Zero,IX,IV,Inf}, MSB first
   localparam int C_FPU01_FLAG_OF   = 5;
   localparam int C_FPU01_FLAG_UF   = 4;
   localparam int C_FPU01_FLAG_ZERO = 3;
   localparam int C_FPU01_FLAG_IX   = 2;
   localparam int C_FPU01_FLAG_IV   = 1;
   localparam int C_FPU01_FLAG_INF  = 0;

   typedef enum logic [C_FPU01_CMD-1:0] {
      FPU_CMD_ADD = 4'd0,
      FPU_CMD_SUB = 4'd1,
      FPU_CMD_MUL = 4'd2,
      FPU_CMD_DIV = 4'd3
   } fpu_cmd_e;

   // id is sized for the 16-requester maximum regardless of NUM_REQ
   typedef struct packed {
      logic       valid;
      logic [3:0] id;
   } fpu_arb_id_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - combinational round-robin pick starting at ptr
module fpu_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    winner,
   output logic               any
);

   logic [ID_W-1:0] idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            winner   = idx;
         end
      end
   end

endmodule

// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - shares one fpu_core among NUM_REQ requesters; FPU_ARB_RESP_REG_EN registers the response
module fpu_share_arbiter
   import fpu_defs::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int FPU_LATENCY = 1
) (
   input  logic                            Clk_CI,
   input  logic                            Rst_RI,
   input  logic [NUM_REQ-1:0]              Req_SI,
   output logic [NUM_REQ-1:0]              Gnt_SO,
   input  logic [NUM_REQ*C_FPU01_OP-1:0]   Operand_a_DI,
   input  logic [NUM_REQ*C_FPU01_OP-1:0]   Operand_b_DI,
   input  logic [NUM_REQ*C_FPU01_CMD-1:0]  OP_SI,
   input  logic [NUM_REQ*C_FPU01_RM-1:0]   RM_SI,
   output logic                            FpuEnable_SO,
   output logic [C_FPU01_OP-1:0]           FpuOperand_a_DO,
   output logic [C_FPU01_OP-1:0]           FpuOperand_b_DO,
   output logic [C_FPU01_CMD-1:0]          FpuOP_SO,
   output logic [C_FPU01_RM-1:0]           FpuRM_SO,
   input  logic [C_FPU01_OP-1:0]           FpuResult_DI,
   input  logic                            FpuValid_SI,
   input  logic [C_FPU01_FLAGS-1:0]        FpuFlags_DI,
   output logic [NUM_REQ-1:0]              RespValid_SO,
   output logic [C_FPU01_OP-1:0]           Result_DO,
   output logic [C_FPU01_FLAGS-1:0]        Flags_DO,
   output logic                            IdErr_SO
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] req_live;
   logic [ID_W-1:0]    winner;
   logic               any;
   fpu_arb_id_t        pipe [FPU_LATENCY];
   fpu_arb_id_t        tail;
   logic [NUM_REQ-1:0] resp_now;
   logic               id_err;

   // Requests are masked while reset is held so the grant follows the zeroed state
   assign req_live = Req_SI & {NUM_REQ{~Rst_RI}};

   fpu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req    (req_live),
      .ptr    (ptr),
      .gnt    (Gnt_SO),
      .winner (winner),
      .any    (any)
   );

   assign FpuEnable_SO = any;

   always_comb begin
      FpuOperand_a_DO = '0;
      FpuOperand_b_DO = '0;
      FpuOP_SO        = '0;
      FpuRM_SO        = '0;
      if (any) begin
         FpuOperand_a_DO = Operand_a_DI[int'(winner)*C_FPU01_OP  +: C_FPU01_OP];
         FpuOperand_b_DO = Operand_b_DI[int'(winner)*C_FPU01_OP  +: C_FPU01_OP];
         FpuOP_SO        = OP_SI[int'(winner)*C_FPU01_CMD +: C_FPU01_CMD];
         FpuRM_SO        = RM_SI[int'(winner)*C_FPU01_RM  +: C_FPU01_RM];
      end
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         ptr <= '0;
      end else if (any) begin
         ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         for (int k = 0; k < FPU_LATENCY; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= '{valid: any, id: 4'(winner)};
         for (int k = 1; k < FPU_LATENCY; k++) pipe[k] <= pipe[k-1];
      end
   end

   assign tail = pipe[FPU_LATENCY-1];

   always_comb begin
      resp_now = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_now[i] = tail.valid && (tail.id == 4'(i));
      end
   end

   // Sticky mismatch between the FPU's own valid and the tracked tail
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         id_err <= 1'b0;
      end else if (tail.valid != FpuValid_SI) begin
         id_err <= 1'b1;
      end
   end

   assign IdErr_SO = id_err;

`ifdef FPU_ARB_RESP_REG_EN
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         RespValid_SO <= '0;
         Result_DO    <= '0;
         Flags_DO     <= '0;
      end else begin
         RespValid_SO <= resp_now;
         Result_DO    <= FpuResult_DI;
         Flags_DO     <= FpuFlags_DI;
      end
   end
`else
   assign RespValid_SO = resp_now;
   assign Result_DO    = FpuResult_DI;
   assign Flags_DO     = FpuFlags_DI;
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - directed bench for fpu_share_arbiter with a lookup-table FPU stand-in
module tb_fpu_share_arbiter;
   import fpu_defs::*;

`ifdef FPU_ARB_RESP_REG_EN
   localparam int RL = 2;
`else
   localparam int RL = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   gnt;
   logic [127:0] opa, opb;
   logic [15:0]  op;
   logic [7:0]   rm;
   logic         fen;
   logic [31:0]  fa, fb;
   logic [3:0]   fop;
   logic [1:0]   frm;
   logic [31:0]  fres;
   logic         fv, force_v;
   logic [5:0]   ffl;
   logic [3:0]   resp;
   logic [31:0]  result;
   logic [5:0]   flags;
   logic         iderr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fpu_share_arbiter #(.NUM_REQ(4), .FPU_LATENCY(1)) dut (
      .Clk_CI          (clk),
      .Rst_RI          (rst),
      .Req_SI          (req),
      .Gnt_SO          (gnt),
      .Operand_a_DI    (opa),
      .Operand_b_DI    (opb),
      .OP_SI           (op),
      .RM_SI           (rm),
      .FpuEnable_SO    (fen),
      .FpuOperand_a_DO (fa),
      .FpuOperand_b_DO (fb),
      .FpuOP_SO        (fop),
      .FpuRM_SO        (frm),
      .FpuResult_DI    (fres),
      .FpuValid_SI     (fv | force_v),
      .FpuFlags_DI     (ffl),
      .RespValid_SO    (resp),
      .Result_DO       (result),
      .Flags_DO        (flags),
      .IdErr_SO        (iderr)
   );

   // Hand-computed IEEE-754 single results for the vectors used; anything else echoes operand a
   function automatic logic [31:0] fpu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      if (c == FPU_CMD_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if (c == FPU_CMD_MUL && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (c == FPU_CMD_SUB && a == b) return 32'h00000000;
      return a;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fv   <= 1'b0;
         fres <= '0;
         ffl  <= '0;
      end else begin
         fv   <= fen;
         fres <= fpu_model(fop, fa, fb);
         ffl  <= (fpu_model(fop, fa, fb) == 32'h0) ? 6'b001000 : 6'b000000;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [1:0] r);
      opa[i*32 +: 32] = a;
      opb[i*32 +: 32] = b;
      op[i*4 +: 4]    = c;
      rm[i*2 +: 2]    = r;
   endtask

   task automatic cyc(input logic [3:0] r);
      @(negedge clk);
      req = r;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 4'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 4'hF; force_v = 1'b0;
      opa = '0; opb = '0; op = '0; rm = '0;
      #12;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_en", 32'(fen), 32'h0);
      check("rst_resp", 32'(resp), 32'h0);
      check("rst_result", result, 32'h0);
      check("rst_iderr", 32'(iderr), 32'h0);
      @(negedge clk);
      rst = 1'b0; req = 4'h0;

      // Single request from R1
      set_lane(1, 32'h3F800000, 32'h40000000, FPU_CMD_ADD, 2'd0);
      cyc(4'b0010);
      check("single_gnt", 32'(gnt), 32'h2);
      check("single_en", 32'(fen), 32'h1);
      check("single_opa", fa, 32'h3F800000);
      check("single_opb", fb, 32'h40000000);
      for (int c = 1; c <= RL; c++) begin
         cyc(4'b0000);
         if (c == 1) check("idle_opa", fa, 32'h0);
         if (c < RL) begin
            check("single_early", 32'(resp), 32'h0);
         end else begin
            check("single_resp", 32'(resp), 32'h2);
            check("single_result", result, 32'h40400000);
            check("single_flags", 32'(flags), 32'h0);
         end
      end
      cyc(4'b0000);
      check("single_pulse", 32'(resp), 32'h0);

      // All four continuously from ptr=0
      do_reset();
      for (int i = 0; i < 4; i++) set_lane(i, 32'h100 + i, 32'h0, 4'hF, 2'd0);
      for (int c = 0; c < 8 + RL; c++) begin
         cyc((c < 8) ? 4'hF : 4'h0);
         if (c < 8) check("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
         if (c >= RL) begin
            check("rr_resp", 32'(resp), 32'(1 << ((c - RL) % 4)));
            check("rr_result", result, 32'h100 + 32'((c - RL) % 4));
         end else begin
            check("rr_resp_early", 32'(resp), 32'h0);
         end
      end

      // Move ptr to 3, then R2+R3 contend
      cyc(4'b0100);
      check("p3_setup_gnt", 32'(gnt), 32'h4);
      repeat (RL + 1) cyc(4'b0000);
      cyc(4'b1100);
      check("p3_gnt_r3", 32'(gnt), 32'h8);
      cyc(4'b1100);
      check("p0_gnt_r2", 32'(gnt), 32'h4);
      repeat (RL + 1) cyc(4'b0000);

      // R0 MUL then R1 SUB back-to-back
      set_lane(0, 32'h40000000, 32'h40400000, FPU_CMD_MUL, 2'd0);
      set_lane(1, 32'h3F800000, 32'h3F800000, FPU_CMD_SUB, 2'd0);
      cyc(4'b0001);
      check("b2b_gnt0", 32'(gnt), 32'h1);
      for (int c = 1; c <= RL + 1; c++) begin
         cyc((c == 1) ? 4'b0010 : 4'b0000);
         if (c == 1) check("b2b_gnt1", 32'(gnt), 32'h2);
         if (c == RL) begin
            check("b2b_resp0", 32'(resp), 32'h1);
            check("b2b_result0", result, 32'h40C00000);
            check("b2b_flags0", 32'(flags), 32'h0);
         end
         if (c == RL + 1) begin
            check("b2b_resp1", 32'(resp), 32'h2);
            check("b2b_result1", result, 32'h0);
            check("b2b_flags1", 32'(flags), 32'h8);
         end
      end
      repeat (2) cyc(4'b0000);

      // Reset one cycle after an issue discards the in-flight ID
      cyc(4'b0001);
      check("rstmid_issue", 32'(gnt), 32'h1);
      @(negedge clk);
      rst = 1'b1; req = 4'h0;
      #1;
      check("rstmid_resp_hold", 32'(resp), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cyc(4'b0000);
         check("rstmid_resp", 32'(resp), 32'h0);
      end
      check("rstmid_iderr", 32'(iderr), 32'h0);
      cyc(4'hF);
      check("rstmid_ptr0", 32'(gnt), 32'h1);
      repeat (RL + 2) cyc(4'b0000);
      check("pre_force_iderr", 32'(iderr), 32'h0);

      // Spurious FPU valid with nothing in flight
      @(negedge clk);
      force_v = 1'b1; req = 4'h0;
      #1;
      check("force_resp", 32'(resp), 32'h0);
      @(negedge clk);
      force_v = 1'b0;
      #1;
      check("force_iderr", 32'(iderr), 32'h1);
      check("force_resp_after", 32'(resp), 32'h0);
      repeat (3) cyc(4'b0000);
      check("force_iderr_sticky", 32'(iderr), 32'h1);
      check("force_resp_late", 32'(resp), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
